// File: rtl/pipe_stage_if.sv
// Handshake bundle for pipe_stage: upstream valid/ready/data, downstream valid/ready/data,
// plus the ctrl hold/flush inputs and the occupancy output.
interface pipe_stage_if #(
  parameter int DW = 32
);
  logic [2:0]    hold_flag_i;
  logic          flush_i;
  logic          in_valid_i;
  logic [DW-1:0] in_data_i;
  logic          in_ready_o;
  logic          out_valid_o;
  logic [DW-1:0] out_data_o;
  logic          out_ready_i;
  logic [1:0]    occ_o;

  modport slave (
    input  hold_flag_i, flush_i, in_valid_i, in_data_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o, occ_o
  );

  modport master (
    output hold_flag_i, flush_i, in_valid_i, in_data_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o, occ_o
  );
endinterface

// File: rtl/pipe_stage.sv
// Pipeline register stage with hold/flush control; define PIPE_SKID_EN to add a skid entry
// that breaks the out_ready -> in_ready combinational path.
module pipe_stage #(
  parameter int            DW       = 32,
  parameter logic [DW-1:0] RST_VAL  = '0,
  parameter logic [2:0]    HOLD_LVL = 3'd2
) (
  input  logic         clk,
  input  logic         rstn,
  pipe_stage_if.slave  bus
);

  logic          hold_en;
  logic          in_fire;
  logic          out_fire;
  logic          main_valid, main_valid_d;
  logic [DW-1:0] main_data,  main_data_d;
  logic [1:0]    occ_q,      occ_d;

  assign hold_en         = (bus.hold_flag_i >= HOLD_LVL);
  assign bus.out_valid_o = main_valid & ~hold_en & ~bus.flush_i;
  assign bus.out_data_o  = main_data;
  assign bus.occ_o       = occ_q;
  assign in_fire         = bus.in_valid_i & bus.in_ready_o;
  assign out_fire        = bus.out_valid_o & bus.out_ready_i;

`ifdef PIPE_SKID_EN
  logic          skid_valid, skid_valid_d;
  logic [DW-1:0] skid_data,  skid_data_d;

  // Ready depends only on registered state, so downstream ready never reaches upstream.
  assign bus.in_ready_o = rstn & ~skid_valid & ~hold_en & ~bus.flush_i;

  always_comb begin
    main_valid_d = main_valid;
    main_data_d  = main_data;
    skid_valid_d = skid_valid;
    skid_data_d  = skid_data;
    if (bus.flush_i) begin
      main_valid_d = 1'b0;
      main_data_d  = RST_VAL;
      skid_valid_d = 1'b0;
      skid_data_d  = RST_VAL;
    end else if (!hold_en) begin
      if (!main_valid || out_fire) begin
        if (skid_valid) begin
          main_valid_d = 1'b1;
          main_data_d  = skid_data;
          skid_valid_d = 1'b0;
        end else if (in_fire) begin
          main_valid_d = 1'b1;
          main_data_d  = bus.in_data_i;
        end else begin
          main_valid_d = 1'b0;
        end
      end else if (in_fire) begin
        skid_valid_d = 1'b1;
        skid_data_d  = bus.in_data_i;
      end
    end
    occ_d = {1'b0, main_valid_d} + {1'b0, skid_valid_d};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      skid_valid <= 1'b0;
      skid_data  <= RST_VAL;
    end else begin
      skid_valid <= skid_valid_d;
      skid_data  <= skid_data_d;
    end
  end
`else
  assign bus.in_ready_o = (~main_valid | bus.out_ready_i) & ~hold_en & ~bus.flush_i;

  always_comb begin
    main_valid_d = main_valid;
    main_data_d  = main_data;
    if (bus.flush_i) begin
      main_valid_d = 1'b0;
      main_data_d  = RST_VAL;
    end else if (!hold_en && (!main_valid || out_fire)) begin
      main_valid_d = in_fire;
      if (in_fire) main_data_d = bus.in_data_i;
    end
    occ_d = {1'b0, main_valid_d};
  end
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      main_valid <= 1'b0;
      main_data  <= RST_VAL;
      occ_q      <= 2'd0;
    end else begin
      main_valid <= main_valid_d;
      main_data  <= main_data_d;
      occ_q      <= occ_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage.sv
// Directed self-checking bench for pipe_stage; build-specific scenarios follow PIPE_SKID_EN.
module tb_pipe_stage;
  localparam logic [31:0] RST_VAL = 32'h0000_0013;

  logic clk;
  logic rstn;
  int   checks;
  int   passes;

  pipe_stage_if #(.DW(32)) bus ();

  pipe_stage #(.DW(32), .RST_VAL(RST_VAL), .HOLD_LVL(3'd2)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic exp_rdy;
`ifdef PIPE_SKID_EN
    exp_rdy = 1'b0;
`else
    exp_rdy = 1'b1;
`endif
    rstn = 1'b0;
    bus.in_valid_i = 1'b1;
    bus.in_data_i  = 32'h1234;
    bus.out_ready_i = 1'b1;
    repeat (2) step();
    checks++; if (bus.out_valid_o !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", bus.out_valid_o); else passes++;
    checks++; if (bus.out_data_o !== RST_VAL) $display("[TB] FAIL reset_data: got %h expected %h", bus.out_data_o, RST_VAL); else passes++;
    checks++; if (bus.occ_o !== 2'd0) $display("[TB] FAIL reset_occ: got %0d expected 0", bus.occ_o); else passes++;
    checks++; if (bus.in_ready_o !== exp_rdy) $display("[TB] FAIL reset_ready: got %b expected %b", bus.in_ready_o, exp_rdy); else passes++;
    rstn = 1'b1;
    step();
    checks++; if ({bus.out_valid_o, bus.out_data_o} !== {1'b1, 32'h1234}) $display("[TB] FAIL reset_first: got %b/%h expected 1/00001234", bus.out_valid_o, bus.out_data_o); else passes++;
    checks++; if (bus.occ_o !== 2'd1) $display("[TB] FAIL reset_first_occ: got %0d expected 1", bus.occ_o); else passes++;
    bus.in_valid_i = 1'b0;
    step();
    checks++; if (bus.out_valid_o !== 1'b0) $display("[TB] FAIL reset_drain: got %b expected 0", bus.out_valid_o); else passes++;
  endtask

  task automatic test_stream;
    logic [31:0] exp_data;
    bus.out_ready_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      exp_data = 32'hA0 + 32'(k);
      bus.in_valid_i = 1'b1;
      bus.in_data_i  = exp_data;
      #1;
      checks++; if (bus.in_ready_o !== 1'b1) $display("[TB] FAIL stream_ready[%0d]: got %b expected 1", k, bus.in_ready_o); else passes++;
      step();
      checks++; if ({bus.out_valid_o, bus.out_data_o} !== {1'b1, exp_data}) $display("[TB] FAIL stream_out[%0d]: got %b/%h expected 1/%h", k, bus.out_valid_o, bus.out_data_o, exp_data); else passes++;
    end
    bus.in_valid_i = 1'b0;
    step();
    checks++; if (bus.out_valid_o !== 1'b0) $display("[TB] FAIL stream_empty: got %b expected 0", bus.out_valid_o); else passes++;
    checks++; if (bus.occ_o !== 2'd0) $display("[TB] FAIL stream_occ: got %0d expected 0", bus.occ_o); else passes++;
  endtask

  task automatic test_backpressure;
    bus.out_ready_i = 1'b0;
    bus.in_valid_i  = 1'b1;
    bus.in_data_i   = 32'hB0;
    step();
`ifdef PIPE_SKID_EN
    checks++; if (bus.in_ready_o !== 1'b1) $display("[TB] FAIL bp_ready_one: got %b expected 1", bus.in_ready_o); else passes++;
    bus.in_data_i = 32'hB1;
    step();
    bus.in_valid_i = 1'b0;
    #1;
    checks++; if (bus.occ_o !== 2'd2) $display("[TB] FAIL bp_occ_full: got %0d expected 2", bus.occ_o); else passes++;
    checks++; if (bus.in_ready_o !== 1'b0) $display("[TB] FAIL bp_ready_full: got %b expected 0", bus.in_ready_o); else passes++;
    checks++; if ({bus.out_valid_o, bus.out_data_o} !== {1'b1, 32'hB0}) $display("[TB] FAIL bp_head: got %b/%h expected 1/000000b0", bus.out_valid_o, bus.out_data_o); else passes++;
    bus.out_ready_i = 1'b1;
    #1;
    checks++; if (bus.in_ready_o !== 1'b0) $display("[TB] FAIL bp_no_comb_ready: got %b expected 0", bus.in_ready_o); else passes++;
    step();
    checks++; if ({bus.out_valid_o, bus.out_data_o} !== {1'b1, 32'hB1}) $display("[TB] FAIL bp_second: got %b/%h expected 1/000000b1", bus.out_valid_o, bus.out_data_o); else passes++;
    checks++; if (bus.in_ready_o !== 1'b1) $display("[TB] FAIL bp_ready_after: got %b expected 1", bus.in_ready_o); else passes++;
    checks++; if (bus.occ_o !== 2'd1) $display("[TB] FAIL bp_occ_one: got %0d expected 1", bus.occ_o); else passes++;
`else
    bus.in_valid_i = 1'b0;
    #1;
    checks++; if (bus.in_ready_o !== 1'b0) $display("[TB] FAIL bp_ready_blocked: got %b expected 0", bus.in_ready_o); else passes++;
    checks++; if (bus.occ_o !== 2'd1) $display("[TB] FAIL bp_occ_one: got %0d expected 1", bus.occ_o); else passes++;
    checks++; if ({bus.out_valid_o, bus.out_data_o} !== {1'b1, 32'hB0}) $display("[TB] FAIL bp_head: got %b/%h expected 1/000000b0", bus.out_valid_o, bus.out_data_o); else passes++;
    bus.out_ready_i = 1'b1;
    #1;
    checks++; if (bus.in_ready_o !== 1'b1) $display("[TB] FAIL bp_ready_same_cycle: got %b expected 1", bus.in_ready_o); else passes++;
`endif
    step();
    checks++; if (bus.out_valid_o !== 1'b0) $display("[TB] FAIL bp_drained: got %b expected 0", bus.out_valid_o); else passes++;
    checks++; if (bus.occ_o !== 2'd0) $display("[TB] FAIL bp_occ_empty: got %0d expected 0", bus.occ_o); else passes++;
  endtask

  task automatic test_hold;
    bus.out_ready_i = 1'b0;
    bus.in_valid_i  = 1'b1;
    bus.in_data_i   = 32'hC0;
    step();
    bus.hold_flag_i = 3'd2;
    bus.out_ready_i = 1'b1;
    bus.in_data_i   = 32'hCF;
    #1;
    checks++; if (bus.out_valid_o !== 1'b0) $display("[TB] FAIL hold_bubble: got %b expected 0", bus.out_valid_o); else passes++;
    checks++; if (bus.in_ready_o !== 1'b0) $display("[TB] FAIL hold_ready: got %b expected 0", bus.in_ready_o); else passes++;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if ({bus.out_valid_o, bus.out_data_o, bus.occ_o} !== {1'b0, 32'hC0, 2'd1}) $display("[TB] FAIL hold_keep[%0d]: got %b/%h/%0d expected 0/000000c0/1", k, bus.out_valid_o, bus.out_data_o, bus.occ_o); else passes++;
    end
    bus.hold_flag_i = 3'd1;
    bus.in_valid_i  = 1'b0;
    #1;
    checks++; if ({bus.out_valid_o, bus.out_data_o} !== {1'b1, 32'hC0}) $display("[TB] FAIL hold_release: got %b/%h expected 1/000000c0", bus.out_valid_o, bus.out_data_o); else passes++;
    step();
    checks++; if (bus.out_valid_o !== 1'b0) $display("[TB] FAIL hold_once: got %b expected 0", bus.out_valid_o); else passes++;
    checks++; if (bus.occ_o !== 2'd0) $display("[TB] FAIL hold_occ: got %0d expected 0", bus.occ_o); else passes++;
    bus.hold_flag_i = 3'd0;
  endtask

  task automatic test_flush;
    logic [1:0] exp_occ;
    bus.out_ready_i = 1'b0;
    bus.in_valid_i  = 1'b1;
    bus.in_data_i   = 32'hD0;
    step();
`ifdef PIPE_SKID_EN
    bus.in_data_i = 32'hD1;
    step();
    exp_occ = 2'd2;
`else
    exp_occ = 2'd1;
`endif
    checks++; if (bus.occ_o !== exp_occ) $display("[TB] FAIL flush_pre_occ: got %0d expected %0d", bus.occ_o, exp_occ); else passes++;
    bus.flush_i     = 1'b1;
    bus.hold_flag_i = 3'd3;
    bus.in_data_i   = 32'hDD;
    bus.out_ready_i = 1'b1;
    #1;
    checks++; if ({bus.out_valid_o, bus.in_ready_o} !== 2'b00) $display("[TB] FAIL flush_gate: got %b%b expected 00", bus.out_valid_o, bus.in_ready_o); else passes++;
    step();
    bus.flush_i     = 1'b0;
    bus.hold_flag_i = 3'd0;
    bus.in_valid_i  = 1'b0;
    #1;
    checks++; if (bus.occ_o !== 2'd0) $display("[TB] FAIL flush_occ: got %0d expected 0", bus.occ_o); else passes++;
    checks++; if (bus.out_data_o !== RST_VAL) $display("[TB] FAIL flush_data: got %h expected %h", bus.out_data_o, RST_VAL); else passes++;
    checks++; if (bus.out_valid_o !== 1'b0) $display("[TB] FAIL flush_valid: got %b expected 0", bus.out_valid_o); else passes++;
    step();
    checks++; if (bus.out_valid_o !== 1'b0) $display("[TB] FAIL flush_nothing: got %b expected 0", bus.out_valid_o); else passes++;
  endtask

  task automatic test_mid_reset;
    bus.out_ready_i = 1'b0;
    bus.in_valid_i  = 1'b1;
    bus.in_data_i   = 32'hE0;
    step();
    bus.in_valid_i = 1'b0;
    checks++; if (bus.occ_o !== 2'd1) $display("[TB] FAIL mrst_pre_occ: got %0d expected 1", bus.occ_o); else passes++;
    rstn = 1'b0;
    #1;
    checks++; if ({bus.occ_o, bus.out_data_o} !== {2'd0, RST_VAL}) $display("[TB] FAIL mrst_async: got %0d/%h expected 0/%h", bus.occ_o, bus.out_data_o, RST_VAL); else passes++;
    step();
    rstn = 1'b1;
    bus.out_ready_i = 1'b1;
    step();
    checks++; if ({bus.out_valid_o, bus.occ_o} !== {1'b0, 2'd0}) $display("[TB] FAIL mrst_empty: got %b/%0d expected 0/0", bus.out_valid_o, bus.occ_o); else passes++;
  endtask

  initial begin
    checks = 0;
    passes = 0;
    rstn = 1'b0;
    bus.hold_flag_i = 3'd0;
    bus.flush_i     = 1'b0;
    bus.in_valid_i  = 1'b0;
    bus.in_data_i   = '0;
    bus.out_ready_i = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_hold();
    test_flush();
    test_mid_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
